// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: EX-stage sequencer for an iterative restoring divider (DIV/DIVU).
// Accepts one request, runs DATA_W restoring steps and returns {remainder, quotient}
// for the HI/LO write path, holding the pipeline via stallreq_o while busy.
// Optional macro DIV_EARLY_EXIT_EN: when |dividend| < |divisor| the result is
// produced directly at accept (quotient 0, remainder = dividend).
module ex_div_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, ZERO, RUN, DONE} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2*DATA_W:0]      work_q, work_d;
  logic [DATA_W-1:0]      dvsr_q, dvsr_d;
  logic                   qneg_q, qneg_d;
  logic                   rneg_q, rneg_d;
  logic [2*DATA_W-1:0]    result_q, result_d;
  logic                   ready_q, ready_d;

  // Magnitude of an operand; only negative values in a signed divide are negated.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                   input logic sgn);
    return (sgn && v[DATA_W-1]) ? (~v + 1'b1) : v;
  endfunction

  // Re-apply a sign to an unsigned magnitude (two's complement, modulo 2^DATA_W).
  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v,
                                                    input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  logic [DATA_W-1:0]      a_mag, b_mag;
  logic [2*DATA_W:0]      shifted;
  logic [DATA_W+1:0]      diff;
  logic [2*DATA_W:0]      step_work;

  assign a_mag = magnitude(opdata1_i, signed_div_i);
  assign b_mag = magnitude(opdata2_i, signed_div_i);

  // One restoring step: shift, trial-subtract divisor from the upper DATA_W+1 bits,
  // keep the difference and set the quotient bit when it did not borrow.
  always_comb begin
    shifted = {work_q[2*DATA_W-1:0], 1'b0};
    diff    = {1'b0, shifted[2*DATA_W:DATA_W]} - {2'b00, dvsr_q};
    if (!diff[DATA_W+1]) begin
      step_work = {diff[DATA_W:0], shifted[DATA_W-1:1], 1'b1};
    end else begin
      step_work = shifted;
    end
  end

  // Next-state, datapath updates and the combinational stall request.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    dvsr_d     = dvsr_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    result_d   = result_q;
    ready_d    = ready_q;
    stallreq_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          stallreq_o = 1'b1;
          dvsr_d     = b_mag;
          qneg_d     = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          rneg_d     = signed_div_i && opdata1_i[DATA_W-1];
          cnt_d      = '0;
          if (opdata2_i == '0) begin
            state_d = ZERO;
`ifdef DIV_EARLY_EXIT_EN
          end else if (a_mag < b_mag) begin
            state_d  = DONE;
            result_d = {opdata1_i, {DATA_W{1'b0}}};
            ready_d  = 1'b1;
`endif
          end else begin
            work_d  = {{(DATA_W+1){1'b0}}, a_mag};
            state_d = RUN;
          end
        end
      end
      ZERO: begin
        stallreq_o = 1'b1;
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          state_d  = DONE;
          result_d = '0;
          ready_d  = 1'b1;
        end
      end
      RUN: begin
        stallreq_o = 1'b1;
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          work_d = step_work;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            state_d  = DONE;
            ready_d  = 1'b1;
            result_d = {apply_sign(step_work[2*DATA_W-1:DATA_W], rneg_q),
                        apply_sign(step_work[DATA_W-1:0], qneg_q)};
          end
        end
      end
      DONE: begin
        if (annul_i || !start_i) begin
          state_d  = IDLE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and work registers; reset aborts any divide in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      dvsr_q   <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      dvsr_q   <= dvsr_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Scoreboard bench for ex_div_ctrl: the driver pushes expected results computed
// with plain arithmetic; a monitor pops and compares whenever ready_o rises.
module tb_ex_div_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] res;
    int          stalls;
  } exp_t;

  exp_t exp_q[$];

  ex_div_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i),
    .signed_div_i(signed_div_i), .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .result_o(result_o), .ready_o(ready_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: signed/unsigned division with truncation toward zero.
  function automatic exp_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] q, r;
    longint ma, mb;
    if (b == 0) begin
      e.res = '0;
      e.stalls = 2;
      return e;
    end
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a; r = 0;
      end else begin
        q = 32'($signed(a) / $signed(b));
        r = 32'($signed(a) % $signed(b));
      end
      ma = longint'($signed(a)); if (ma < 0) ma = -ma;
      mb = longint'($signed(b)); if (mb < 0) mb = -mb;
    end else begin
      q = a / b;
      r = a % b;
      ma = longint'(a);
      mb = longint'(b);
    end
    e.res = {r, q};
    e.stalls = 33;
`ifdef DIV_EARLY_EXIT_EN
    if (ma < mb) e.stalls = 1;
`else
    if (ma < 0 || mb < 0) e.stalls = 0;
`endif
    return e;
  endfunction

  // Monitor: counts stall cycles per operation and checks each result as it appears.
  initial begin
    int          stall_cnt;
    logic        prev_ready;
    exp_t        cur;
    exp_t        e;
    stall_cnt  = 0;
    prev_ready = 1'b0;
    cur.res    = '0;
    cur.stalls = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst || annul_i) begin
        stall_cnt = 0;
      end else begin
        if (stallreq_o) stall_cnt++;
        if (ready_o && !prev_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_ready", 64'(ready_o), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("result", result_o, e.res);
            check("stall_cycles", 64'(stall_cnt), 64'(e.stalls));
            cur = e;
          end
          stall_cnt = 0;
        end else if (ready_o && prev_ready) begin
          check("result_hold", result_o, cur.res);
        end
      end
      prev_ready = ready_o;
    end
  end

  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    int n;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    exp_q.push_back(model(sgn, a, b));
    @(negedge clk);
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = $urandom_range(0, 1);
    n = 0;
    while (!ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 64'(n >= 200), 64'd0);
    repeat (hold) @(negedge clk);
    start_i = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b;
    logic        sgn;
    #1;
    check("reset_result", result_o, 64'd0);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_stall", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    do_div(1'b0, 32'd100, 32'd7, 0);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_div(1'b0, 32'h1234_5678, 32'd0, 2);
    do_div(1'b0, 32'd3, 32'd10, 0);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    do_div(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    // start and annul together: no accept
    @(negedge clk);
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
    #1 check("start_annul_stall", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    #1 check("start_annul_ready", 64'(ready_o), 64'd0);
    check("start_annul_idle_stall", 64'(stallreq_o), 64'd0);

    // annul on RUN step 10
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    exp_q.push_back(model(1'b0, 32'd100, 32'd7));
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    void'(exp_q.pop_back());
    #1 check("annul_stall", 64'(stallreq_o), 64'd0);
    check("annul_ready", 64'(ready_o), 64'd0);
    repeat (3) @(negedge clk);
    check("annul_ready_later", 64'(ready_o), 64'd0);
    do_div(1'b0, 32'd9, 32'd3, 0);

    // reset in the middle of RUN
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    exp_q.push_back(model(1'b0, 32'd1000, 32'd3));
    repeat (6) @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    void'(exp_q.pop_back());
    #1 check("midrun_rst_result", result_o, 64'd0);
    check("midrun_rst_ready", 64'(ready_o), 64'd0);
    check("midrun_rst_stall", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    do_div(1'b1, 32'hFFFF_FF9C, 32'd7, 0);

    // randomized operations
    for (int i = 0; i < 40; i++) begin
      sgn = $urandom_range(0, 1);
      a   = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 15);
        3: b = a + $urandom_range(1, 4);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      do_div(sgn, a, b, $urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
